auth_req_arbiter: RTL

- Front-end controller for the UID authorization LUT. Shares the LUT between two requesters:
  - the reader path (frame parser, card taps; CHECK only)
  - the admin path (host/UART; CHECK and ADD)
- Validates each request, issues a single-cycle command strobe to the LUT, decodes the LUT flags into a status byte, and returns it over a valid/ready response channel.
- Sits between the frame parser/host bridge and the LUT; the LUT outputs are registered on the strobe edge.

---
 rtl/auth_req_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/auth_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : auth_req_arbiter
//  Description : Shares the UID authorization LUT between the reader path
//                (CHECK only) and the admin path (CHECK/ADD). Round-robin
//                arbitration, request validation, one-cycle LUT strobe,
//                status decode and valid/ready response per requester.
//  Revision    : 1.0  initial release
// ============================================================================
module auth_req_arbiter #(
   parameter int UID_LEN = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_req_valid,
   output logic               rd_req_ready,
   input  logic [7:0]         rd_req_cmd,
   input  logic [127:0]       rd_req_uid_flat,
   input  logic [7:0]         rd_req_uid_len,
   output logic               rd_resp_valid,
   input  logic               rd_resp_ready,
   output logic [7:0]         rd_resp_status,
   input  logic               adm_req_valid,
   output logic               adm_req_ready,
   input  logic [7:0]         adm_req_cmd,
   input  logic [127:0]       adm_req_uid_flat,
   input  logic [7:0]         adm_req_uid_len,
   output logic               adm_resp_valid,
   input  logic               adm_resp_ready,
   output logic [7:0]         adm_resp_status,
   output logic               lut_valid,
   output logic [7:0]         lut_cmd,
   output logic [127:0]       lut_uid_bytes_flat,
   output logic [7:0]         lut_uid_len,
   input  logic               lut_uid_allowed,
   input  logic               lut_uid_added_ok,
   input  logic               lut_uid_duplicate,
   input  logic               lut_uid_full,
   output logic               busy,
   output logic [CNT_W-1:0]   deny_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [7:0] CMD_CHECK   = 8'h10;
   localparam logic [7:0] CMD_ADD     = 8'h11;
   localparam logic [7:0] ST_OK       = 8'h00;
   localparam logic [7:0] ST_DENIED   = 8'h01;
   localparam logic [7:0] ST_DUP      = 8'h02;
   localparam logic [7:0] ST_FULL     = 8'h03;
   localparam logic [7:0] ST_BAD_CMD  = 8'h04;
   localparam logic [7:0] ST_BAD_LEN  = 8'h05;
   localparam logic [7:0] ST_INTERNAL = 8'h06;
   localparam logic [7:0] MAX_LEN     = 8'(UID_LEN);

   localparam logic OWNER_RD  = 1'b0;
   localparam logic OWNER_ADM = 1'b1;

   logic [1:0]       state;
   logic             last_grant;
   logic             owner;
   logic [7:0]       lat_cmd;
   logic [127:0]     lat_uid;
   logic [7:0]       lat_len;
   logic [7:0]       status;
   logic [CNT_W-1:0] deny_cnt;

   logic             grant_rd;
   logic             grant_adm;
   logic             accept;
   logic [7:0]       sel_cmd;
   logic [127:0]     sel_uid;
   logic [7:0]       sel_len;
   logic             bad_cmd;
   logic             bad_len;
   logic [7:0]       lut_status;
   logic             owner_resp_ready;
   logic             lut_drive;

   // Round-robin grant in IDLE; the side that did not win last time wins a tie
   always_comb begin
      grant_rd  = 1'b0;
      grant_adm = 1'b0;
      if (state == S_IDLE && !rst) begin
         if (rd_req_valid && adm_req_valid) begin
            if (last_grant == OWNER_ADM) grant_rd  = 1'b1;
            else                         grant_adm = 1'b1;
         end else begin
            grant_rd  = rd_req_valid;
            grant_adm = adm_req_valid;
         end
      end
   end

   assign accept  = grant_rd | grant_adm;
   assign sel_cmd = grant_adm ? adm_req_cmd      : rd_req_cmd;
   assign sel_uid = grant_adm ? adm_req_uid_flat : rd_req_uid_flat;
   assign sel_len = grant_adm ? adm_req_uid_len  : rd_req_uid_len;

   // Accept-time validation; the reader path may never ADD
   always_comb begin
      bad_cmd = !(sel_cmd == CMD_CHECK || sel_cmd == CMD_ADD) ||
                (grant_rd && sel_cmd == CMD_ADD);
      bad_len = (sel_len == 8'd0) || (sel_len > MAX_LEN);
   end

   // Decode LUT flags into a status byte; FULL outranks DUP for ADD
   always_comb begin
      lut_status = ST_INTERNAL;
      if (lat_cmd == CMD_CHECK) begin
         lut_status = lut_uid_allowed ? ST_OK : ST_DENIED;
      end else if (lut_uid_full) begin
         lut_status = ST_FULL;
      end else if (lut_uid_duplicate) begin
         lut_status = ST_DUP;
      end else if (lut_uid_added_ok) begin
         lut_status = ST_OK;
      end
   end

   assign owner_resp_ready = (owner == OWNER_ADM) ? adm_resp_ready : rd_resp_ready;

   // Control FSM, request latch, status register and saturating denial counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         last_grant <= OWNER_ADM;
         owner      <= OWNER_RD;
         lat_cmd    <= '0;
         lat_uid    <= '0;
         lat_len    <= '0;
         status     <= '0;
         deny_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lat_cmd    <= sel_cmd;
                  lat_uid    <= sel_uid;
                  lat_len    <= sel_len;
                  owner      <= grant_adm;
                  last_grant <= grant_adm;
                  if (bad_cmd) begin
                     status <= ST_BAD_CMD;
                     state  <= S_RESP;
                  end else if (bad_len) begin
                     status <= ST_BAD_LEN;
                     state  <= S_RESP;
                  end else begin
                     state  <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               status <= lut_status;
               state  <= S_RESP;
               if (owner == OWNER_RD && lut_status == ST_DENIED &&
                   deny_cnt != {CNT_W{1'b1}}) begin
                  deny_cnt <= deny_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            S_RESP: begin
               if (owner_resp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign lut_drive          = (state == S_ISSUE) || (state == S_WAIT);
   assign lut_valid          = (state == S_ISSUE);
   assign lut_cmd            = lut_drive ? lat_cmd : 8'h00;
   assign lut_uid_bytes_flat = lut_drive ? lat_uid : 128'h0;
   assign lut_uid_len        = lut_drive ? lat_len : 8'h00;

   assign rd_req_ready    = grant_rd;
   assign adm_req_ready   = grant_adm;
   assign rd_resp_valid   = (state == S_RESP) && (owner == OWNER_RD);
   assign adm_resp_valid  = (state == S_RESP) && (owner == OWNER_ADM);
   assign rd_resp_status  = rd_resp_valid  ? status : 8'h00;
   assign adm_resp_status = adm_resp_valid ? status : 8'h00;
   assign busy            = (state != S_IDLE);
   assign deny_count      = deny_cnt;

endmodule
`default_nettype wire
